core_inst_seq: RTL and testbench

Instruction sequencer that generates the 47-bit `inst` word consumed by `core`, driving one complete weight-stationary tile pass. A pass loads weights, streams activations, and drains the output FIFO into pmem, with optional accumulation. The block sits between the testbench/host and `core`, replaces hand-written instruction vectors, and reacts to `ofifo_valid` from the core.

---
 rtl/core_inst_seq.sv | 190 +++++++++++++++++++
 tb/tb_core_inst_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_seq.sv
// Instruction sequencer for one weight-stationary tile pass of core:
// weight load, activation streaming and ofifo drain into pmem.
//
// state  | meaning
// IDLE   | waiting for start, idle word on inst
// W_L0   | xmem weight reads into L0 (row+1 cycles)
// W_LOAD | L0 -> PE weight load (row cycles)
// W_GAP  | pipeline settle before activations (row+col cycles)
// A_L0   | xmem activation reads into L0 (n_act+1 cycles)
// A_EXE  | execute, L0 streams activations (n_act cycles)
// DRAIN  | ofifo reads, pmem writes one cycle later, optional accumulate
// DONE   | one-cycle done pulse
module core_inst_seq #(
   parameter int row = 8,
   parameter int col = 8,
   parameter int aw  = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [aw-1:0] w_base,
   input  logic [aw-1:0] a_base,
   input  logic [aw-1:0] p_base,
   input  logic [aw-1:0] n_act,
   input  logic          acc_en,
   input  logic          mode,
   input  logic          ofifo_valid,
   output logic [46:0]   inst,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {IDLE, W_L0, W_LOAD, W_GAP, A_L0, A_EXE, DRAIN, DONE} state_t;

   localparam int GW = $clog2(row + col + 1);
   localparam int CW = ((aw + 1) > GW) ? (aw + 1) : GW;
   localparam logic [46:0] IDLE_WORD = 47'h1C00000C0000;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [aw-1:0]   w_base_r, a_base_r, p_base_r, n_r;
   logic            acc_r, mode_r;
   logic [aw-1:0]   rd_cnt, wr_cnt;
   logic            wr_pend;
   logic            rd_issue, wr_issue;
   logic [46:0]     inst_nxt;
   logic            busy_nxt, done_nxt;
   logic [aw-1:0]   wb_e;
   logic            mode_e;

   // The first W_L0 word is built on the accepting edge, before the config registers load.
   assign wb_e   = (state == IDLE) ? w_base : w_base_r;
   assign mode_e = (state == IDLE) ? mode : mode_r;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      rd_issue  = 1'b0;
      wr_issue  = 1'b0;
      inst_nxt  = IDLE_WORD;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (start) state_nxt = W_L0;
         end
         W_L0: if (cnt == CW'(row)) begin
            state_nxt = W_LOAD;
            cnt_nxt   = '0;
         end
         W_LOAD: if (cnt_nxt == CW'(row)) begin
            state_nxt = W_GAP;
            cnt_nxt   = '0;
         end
         W_GAP: if (cnt_nxt == CW'(row + col)) begin
            state_nxt = (n_r == '0) ? DONE : A_L0;
            cnt_nxt   = '0;
         end
         A_L0: if (cnt == CW'(n_r)) begin
            state_nxt = A_EXE;
            cnt_nxt   = '0;
         end
         A_EXE: if (cnt_nxt == CW'(n_r)) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
         end
         DRAIN: begin
            cnt_nxt = '0;
            if (wr_cnt == n_r) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
      done_nxt = (state_nxt == DONE);
      if (busy_nxt) inst_nxt[46] = mode_e;

      case (state_nxt)
         W_L0: begin
            if (cnt_nxt < CW'(row)) begin
               inst_nxt[19]   = 1'b0;
               inst_nxt[17:7] = wb_e + aw'(cnt_nxt);
            end
            if (cnt_nxt != '0) inst_nxt[2] = 1'b1;
         end
         W_LOAD: begin
            inst_nxt[0] = 1'b1;
            inst_nxt[3] = 1'b1;
         end
         A_L0: begin
            if (cnt_nxt < CW'(n_r)) begin
               inst_nxt[19]   = 1'b0;
               inst_nxt[17:7] = a_base_r + aw'(cnt_nxt);
            end
            if (cnt_nxt != '0) inst_nxt[2] = 1'b1;
         end
         A_EXE: begin
            inst_nxt[1] = 1'b1;
            inst_nxt[3] = 1'b1;
         end
         DRAIN: begin
            inst_nxt[45] = acc_r;
            rd_issue     = ofifo_valid && (rd_cnt < n_r);
            wr_issue     = wr_pend;
            if (rd_issue) begin
               inst_nxt[6] = 1'b1;
               if (acc_r) begin
                  inst_nxt[44]    = 1'b0;
                  inst_nxt[43]    = 1'b0;
                  inst_nxt[30:20] = p_base_r + rd_cnt;
               end
            end
            // Write-back trails its ofifo read by exactly one cycle.
            if (wr_issue) begin
               inst_nxt[44]    = 1'b0;
               inst_nxt[42]    = 1'b0;
               inst_nxt[41:31] = p_base_r + wr_cnt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         w_base_r <= '0;
         a_base_r <= '0;
         p_base_r <= '0;
         n_r      <= '0;
         acc_r    <= 1'b0;
         mode_r   <= 1'b0;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         wr_pend  <= 1'b0;
         inst     <= IDLE_WORD;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         inst  <= inst_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         if ((state == IDLE) && start) begin
            w_base_r <= w_base;
            a_base_r <= a_base;
            p_base_r <= p_base;
            n_r      <= n_act;
            acc_r    <= acc_en;
            mode_r   <= mode;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            wr_pend  <= 1'b0;
         end else begin
            rd_cnt  <= rd_cnt + aw'(rd_issue);
            wr_cnt  <= wr_cnt + aw'(wr_issue);
            wr_pend <= rd_issue;
         end
      end
   end

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: passes push expected xmem/pmem addresses
// and done timing; a negedge monitor pops and compares as the words appear.
module tb_core_inst_seq;
   localparam int ROW = 8;
   localparam int COL = 8;
   localparam int AW  = 11;
   localparam logic [46:0] IDLE_W = 47'h1C00000C0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] w_base = '0, a_base = '0, p_base = '0, n_act = '0;
   logic          acc_en = 1'b0, mode = 1'b0, ofifo_valid = 1'b1;
   logic [46:0]   inst;
   logic          busy, done;

   always #5 clk = ~clk;

   core_inst_seq #(.row(ROW), .col(COL), .aw(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .w_base(w_base), .a_base(a_base), .p_base(p_base), .n_act(n_act),
      .acc_en(acc_en), .mode(mode), .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done)
   );

   typedef struct {
      int   done_cyc;
      int   n_exe;
      int   n_load;
      logic acc;
      logic md;
   } pass_t;

   logic [AW-1:0] q_x[$], q_pw[$], q_pr[$];
   pass_t         q_pass[$];
   int            cyc = 0;
   int            n_chk = 0, n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor
   logic prev_xrd = 1'b0, prev_ofrd = 1'b0, prev_vld = 1'b0;
   int   cnt_exe = 0, cnt_load = 0;

   always @(negedge clk) begin
      logic  xrd, pw, pr;
      pass_t cur;
      if (!reset) begin
         prev_xrd = 1'b0; prev_ofrd = 1'b0; prev_vld = 1'b0;
         cnt_exe = 0; cnt_load = 0;
      end else if (q_pass.size() == 0) begin
         check("idle_word", inst, IDLE_W);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         prev_xrd = 1'b0; prev_ofrd = 1'b0; prev_vld = ofifo_valid;
      end else begin
         cur = q_pass[0];
         xrd = !inst[19];
         pw  = !inst[44] && !inst[42];
         pr  = !inst[44] && !inst[43];
         if (xrd) begin
            check("xmem_expected", q_x.size() != 0, 1);
            if (q_x.size() != 0) check("xmem_addr", inst[17:7], q_x.pop_front());
            check("xmem_wen", inst[18], 1);
            check("acc_outside_drain", inst[45], 0);
            check("mode_bit", inst[46], cur.md);
         end
         if (inst[2] || prev_xrd) check("l0_wr_lag", inst[2], prev_xrd);
         if (inst[6]) check("ofifo_rd_gate", prev_vld, 1);
         if (inst[45]) check("acc_only_when_en", 1, cur.acc);
         if (pw) begin
            check("pmem_wr_expected", q_pw.size() != 0, 1);
            if (q_pw.size() != 0) check("pmem_wr_addr", inst[41:31], q_pw.pop_front());
            check("wr_after_ofifo_rd", prev_ofrd, 1);
            check("acc_in_drain", inst[45], cur.acc);
         end
         if (pr) begin
            check("pmem_rd_expected", q_pr.size() != 0, 1);
            if (q_pr.size() != 0) check("pmem_rd_addr", inst[30:20], q_pr.pop_front());
            check("pmem_rd_with_ofifo", inst[6], 1);
         end
         if (inst[1]) cnt_exe++;
         if (inst[0]) cnt_load++;
         if (done) begin
            void'(q_pass.pop_front());
            check("done_cycle", cyc, cur.done_cyc);
            check("done_busy_low", busy, 0);
            check("done_word", inst, IDLE_W);
            check("exec_count", cnt_exe, cur.n_exe);
            check("load_count", cnt_load, cur.n_load);
            check("xmem_left", q_x.size(), 0);
            check("pmem_wr_left", q_pw.size(), 0);
            check("pmem_rd_left", q_pr.size(), 0);
            cnt_exe = 0; cnt_load = 0;
         end
         prev_xrd = xrd; prev_ofrd = inst[6]; prev_vld = ofifo_valid;
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   // Reference: one pass is accept + (row+1) + row + (row+col) [+ (N+1) + N + (N+1)] + done,
   // and every sample of ofifo_valid=0 while reads remain delays done by one cycle.
   task automatic issue_pass(input int wb, input int ab, input int pb, input int n,
                             input logic acc, input logic md, output int s);
      pass_t p;
      int    total;
      @(posedge clk); #1;
      s = cyc;
      for (int k = 0; k < ROW; k++) q_x.push_back(AW'(wb + k));
      for (int k = 0; k < n; k++) begin
         q_x.push_back(AW'(ab + k));
         q_pw.push_back(AW'(pb + k));
         if (acc) q_pr.push_back(AW'(pb + k));
      end
      total = 1 + (ROW + 1) + ROW + (ROW + COL) + 1 + ((n > 0) ? (3 * n + 2) : 0);
      p.done_cyc = s + total - 1;
      p.n_exe = n; p.n_load = ROW; p.acc = acc; p.md = md;
      q_pass.push_back(p);
      w_base = AW'(wb); a_base = AW'(ab); p_base = AW'(pb); n_act = AW'(n);
      acc_en = acc; mode = md; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      w_base = AW'($urandom); a_base = AW'($urandom); p_base = AW'($urandom);
      n_act = AW'($urandom); acc_en = 1'($urandom); mode = 1'($urandom);
   endtask

   task automatic finish_pass();
      for (int i = 0; i < 3000 && q_pass.size() != 0; i++) @(posedge clk);
      check("done_seen", q_pass.size() == 0, 1);
      if (q_pass.size() != 0) begin
         q_pass.delete(); q_x.delete(); q_pw.delete(); q_pr.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic run_pass(input int wb, input int ab, input int pb, input int n,
                           input logic acc, input logic md, input int st_off,
                           input int st_len, input logic glitch);
      int s, d_edge;
      issue_pass(wb, ab, pb, n, acc, md, s);
      if (st_len > 0) q_pass[q_pass.size()-1].done_cyc += st_len;
      if (glitch) begin
         wait_cyc(s + 10);
         start = 1'b1; w_base = AW'($urandom); n_act = AW'($urandom_range(0, 3));
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (st_len > 0) begin
         d_edge = s + 1 + (ROW + 1) + ROW + (ROW + COL) + (n + 1) + n;
         wait_cyc(d_edge + st_off - 1);
         ofifo_valid = 1'b0;
         wait_cyc(d_edge + st_off + st_len - 1);
         ofifo_valid = 1'b1;
      end
      finish_pass();
   endtask

   initial begin
      int s, n, off, len;
      #2 reset = 1'b0;
      #1;
      check("reset_inst", inst, IDLE_W);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);

      run_pass(0, 8, 0, 4, 1'b0, 1'b0, 0, 0, 1'b0);
      run_pass(0, 8, 0, 4, 1'b0, 1'b1, 2, 3, 1'b0);
      run_pass(2044, 8, 2046, 4, 1'b1, 1'b1, 0, 0, 1'b0);
      run_pass(5, 100, 7, 0, 1'b1, 1'b0, 0, 0, 1'b0);

      // Abort in A_EXE, then a complete replay.
      issue_pass(0, 8, 0, 4, 1'b0, 1'b0, s);
      for (int i = 0; i < 200 && !inst[1]; i++) begin
         @(posedge clk); #1;
      end
      check("reached_exec", inst[1], 1);
      #2 reset = 1'b0;
      #1;
      check("abort_inst", inst, IDLE_W);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      q_pass.delete(); q_x.delete(); q_pw.delete(); q_pr.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      run_pass(0, 8, 0, 4, 1'b0, 1'b0, 0, 0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(0, 6);
         off = 0; len = 0;
         if (n >= 2 && $urandom_range(0, 1) == 1) begin
            off = $urandom_range(1, n - 1);
            len = $urandom_range(1, 3);
         end
         run_pass($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                  n, 1'($urandom), 1'($urandom), off, len, 1'b1);
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
